// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, winning line index triples and
// the reward class encoding used by the reward generator.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;
    localparam logic [1:0] CELL_BAD   = 2'b11;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    // Rows, then columns, then the two diagonals; cell 0 is top-left, row-major.
    localparam int LINE_CELLS [NUM_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    typedef enum logic [2:0] {
        RC_STEP,
        RC_WIN,
        RC_LOSE,
        RC_DRAW,
        RC_INVALID
    } reward_class_e;

endpackage

// File: rtl/ttt_line_detect.sv
// Combinational check for whether any of the eight lines is fully owned by
// the given player code.
module ttt_line_detect
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  player,
    output logic        line_present
);

    always_comb begin
        line_present = 1'b0;
        for (int l = 0; l < NUM_LINES; l++) begin
            if (board[2*LINE_CELLS[l][0] +: 2] == player &&
                board[2*LINE_CELLS[l][1] +: 2] == player &&
                board[2*LINE_CELLS[l][2] +: 2] == player) begin
                line_present = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reward_gen.sv
// Classifies the board every cycle into invalid/win/lose/draw/step and
// registers the signed reward together with the status flags.
module reward_gen
    import ttt_pkg::*;
#(
    parameter logic signed [7:0] REWARD_WIN     = 8'sd100,
    parameter logic signed [7:0] REWARD_LOSE    = -8'sd100,
    parameter logic signed [7:0] REWARD_DRAW    = 8'sd10,
    parameter logic signed [7:0] REWARD_STEP    = 8'sd0,
    parameter logic signed [7:0] REWARD_INVALID = 8'sh80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] current_state,
    output logic [7:0]  reward,
    output logic        win,
    output logic        lose,
    output logic        draw,
    output logic        invalid,
    output logic        game_over
);

    logic          x_line;
    logic          o_line;
    logic          full;
    logic          bad_cell;
    reward_class_e rc;
    logic [7:0]    reward_nxt;

    ttt_line_detect u_line_x (
        .board        (current_state),
        .player       (CELL_X),
        .line_present (x_line)
    );

    ttt_line_detect u_line_o (
        .board        (current_state),
        .player       (CELL_O),
        .line_present (o_line)
    );

    always_comb begin
        full     = 1'b1;
        bad_cell = 1'b0;
        for (int c = 0; c < NUM_CELLS; c++) begin
            if (current_state[2*c +: 2] == CELL_EMPTY) full = 1'b0;
            if (current_state[2*c +: 2] == CELL_BAD)   bad_cell = 1'b1;
        end
    end

    // Both players owning a line cannot arise from legal play, so it is
    // folded into the invalid class rather than rewarded either way.
    always_comb begin
        if (bad_cell || (x_line && o_line)) rc = RC_INVALID;
        else if (x_line)                    rc = RC_WIN;
        else if (o_line)                    rc = RC_LOSE;
        else if (full)                      rc = RC_DRAW;
        else                                rc = RC_STEP;
    end

    always_comb begin
        case (rc)
            RC_WIN:     reward_nxt = REWARD_WIN;
            RC_LOSE:    reward_nxt = REWARD_LOSE;
            RC_DRAW:    reward_nxt = REWARD_DRAW;
            RC_INVALID: reward_nxt = REWARD_INVALID;
            default:    reward_nxt = REWARD_STEP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reward    <= 8'h00;
            win       <= 1'b0;
            lose      <= 1'b0;
            draw      <= 1'b0;
            invalid   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            reward    <= reward_nxt;
            win       <= (rc == RC_WIN);
            lose      <= (rc == RC_LOSE);
            draw      <= (rc == RC_DRAW);
            invalid   <= (rc == RC_INVALID);
            game_over <= (rc != RC_STEP);
        end
    end

endmodule

// File: tb/tb_reward_gen.sv
// Directed-vector bench for reward_gen with hand-computed rewards and flags.
module tb_reward_gen;

    logic        clk;
    logic        rst_n;
    logic [17:0] current_state;
    logic [7:0]  reward;
    logic        win;
    logic        lose;
    logic        draw;
    logic        invalid;
    logic        game_over;

    int n_vec;
    int n_err;

    localparam int NV = 12;
    logic [17:0] vec_board  [NV];
    logic [7:0]  vec_reward [NV];
    logic [4:0]  vec_flags  [NV];   // {win, lose, draw, invalid, game_over}

    reward_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .current_state (current_state),
        .reward        (reward),
        .win           (win),
        .lose          (lose),
        .draw          (draw),
        .invalid       (invalid),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [4:0] flags();
        return {win, lose, draw, invalid, game_over};
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;

        vec_board[0]  = 18'h00015; vec_reward[0]  = 8'h64; vec_flags[0]  = 5'b10001; // X top row
        vec_board[1]  = 18'h0002A; vec_reward[1]  = 8'h9C; vec_flags[1]  = 5'b01001; // O top row
        vec_board[2]  = 18'h16A59; vec_reward[2]  = 8'h0A; vec_flags[2]  = 5'b00101; // draw
        vec_board[3]  = 18'h00003; vec_reward[3]  = 8'h80; vec_flags[3]  = 5'b00011; // cell 0 bad
        vec_board[4]  = 18'h00A95; vec_reward[4]  = 8'h80; vec_flags[4]  = 5'b00011; // both lines
        vec_board[5]  = 18'h00011; vec_reward[5]  = 8'h00; vec_flags[5]  = 5'b00000; // in progress
        vec_board[6]  = 18'h04104; vec_reward[6]  = 8'h64; vec_flags[6]  = 5'b10001; // X column 1
        vec_board[7]  = 18'h02220; vec_reward[7]  = 8'h9C; vec_flags[7]  = 5'b01001; // O anti-diagonal
        vec_board[8]  = 18'h30000; vec_reward[8]  = 8'h80; vec_flags[8]  = 5'b00011; // cell 8 bad
        vec_board[9]  = 18'h01055; vec_reward[9]  = 8'h64; vec_flags[9]  = 5'b10001; // two X lines
        vec_board[10] = 18'h26695; vec_reward[10] = 8'h64; vec_flags[10] = 5'b10001; // full board, X wins
        vec_board[11] = 18'h00000; vec_reward[11] = 8'h00; vec_flags[11] = 5'b00000; // empty

        rst_n         = 1'b0;
        current_state = 18'h00000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reward", {24'd0, reward}, 32'h00);
        chk("rst_flags",  {27'd0, flags()}, 32'h00);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("empty_reward", {24'd0, reward}, 32'h00);
        chk("empty_flags",  {27'd0, flags()}, 32'h00);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            current_state = vec_board[i];
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_reward", i), {24'd0, reward}, {24'd0, vec_reward[i]});
            chk($sformatf("v%0d_flags", i),  {27'd0, flags()}, {27'd0, vec_flags[i]});
        end

        @(negedge clk);
        current_state = 18'h00015;
        @(posedge clk);
        #1;
        chk("pre_rst_reward", {24'd0, reward}, 32'h64);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_reward", {24'd0, reward}, 32'h00);
        chk("mid_rst_flags",  {27'd0, flags()}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_reward", {24'd0, reward}, 32'h64);
        chk("post_rst_flags",  {27'd0, flags()}, 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reward_gen.md
Name: reward_gen

Overview:
- Registered reward generator for the tic-tac-toe reinforcement-learning datapath.
- Each cycle it takes the 18-bit board encoding and classifies it as invalid, agent win, opponent win, draw, or in-progress.
- It outputs a signed 8-bit reward plus status flags, which the Q-value update logic consumes.

Parameters:
- REWARD_WIN, 8'sd100, reward when agent (X) has a line.
- REWARD_LOSE, -8'sd100, reward when opponent (O) has a line.
- REWARD_DRAW, 8'sd10, reward for a full board with no line.
- REWARD_STEP, 8'sd0, reward for a legal, unfinished game.
- REWARD_INVALID, -8'sd128, reward for an illegal encoding.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- current_state  input  18  board; cell i occupies bits [2i+1:2i].
- reward  output  8  signed two's-complement reward, registered.
- win  output  1  registered: X has a line.
- lose  output  1  registered: O has a line.
- draw  output  1  registered: board full, no line.
- invalid  output  1  registered: illegal board.
- game_over  output  1  registered: win | lose | draw | invalid.

Behaviour:
- Cell encoding: 2'b00 empty, 2'b01 X (agent), 2'b10 O (opponent), 2'b11 illegal.
- Cell numbering: cell 0 is top-left, row-major; cell 8 is bottom-right.
- Lines checked (8 total):
  - rows {0,1,2}, {3,4,5}, {6,7,8}
  - columns {0,3,6}, {1,4,7}, {2,5,8}
  - diagonals {0,4,8}, {2,4,6}
- A line belongs to a player when all three of its cells equal that player's code.
- x_line is set if any line belongs to X; o_line is set if any line belongs to O.
- full is set when no cell is 2'b00.
- Classification, highest priority first:
  - invalid: any cell is 2'b11, or x_line and o_line are both set.
  - win: x_line.
  - lose: o_line.
  - draw: full and no line.
  - step: otherwise.
- Exactly one class is active per evaluation.
- Multiple lines for the same player count as a single win or lose; the reward is not accumulated.
- Move-count parity (X count vs O count) is not checked.
- Latency: outputs reflect the current_state sampled at rising edge N and are valid after edge N. No handshake; the block evaluates every cycle.
- Classification is fully combinational, then one register stage covers reward and all flags.
- Reset (asynchronous, rst_n low): reward = 0; win, lose, draw, invalid, game_over = 0.
- Reset is held while rst_n is low. Asserting it mid-operation clears outputs immediately.
- The first evaluation occurs at the first rising edge after rst_n deasserts.
- Parameter overrides are truncated to 8 bits signed; no saturation logic is required.

Decomposition:
- Shared package ttt_pkg holds:
  - cell codes CELL_EMPTY, CELL_X, CELL_O, CELL_BAD;
  - the 8 line-index triples as a constant array;
  - the reward_class enum {RC_STEP, RC_WIN, RC_LOSE, RC_DRAW, RC_INVALID}.
- One sub-module, ttt_line_detect, is natural. It is combinational, takes the 18-bit board and a player code, and returns a 1-bit line-present signal. It is instantiated twice (X and O).
- Full-board detection, priority encoding and the register stage live in reward_gen.

Test Plan:
- Reset and empty board: hold rst_n=0 with current_state=18'h00000, then release. Required: reward=8'h00 and all flags 0, both during reset and after one clock.
- X top-row win and O top-row win:
  - current_state=18'h00015 → reward=8'h64, win=1, game_over=1 one cycle later.
  - current_state=18'h0002A → reward=8'h9C, lose=1.
- Draw: current_state=18'h16A59 (X O X / X O O / O X X) → reward=8'h0A, draw=1, game_over=1.
- Invalid:
  - current_state=18'h00003 (cell 0 = 2'b11) → reward=8'h80, invalid=1.
  - current_state=18'h00A95 (X row 0 and O row 1) → reward=8'h80, invalid=1.
- In-progress and reset mid-operation:
  - current_state=18'h00011 (X in cells 0 and 2) → reward=8'h00, game_over=0.
  - Then apply 18'h00015 and pulse rst_n low between clock edges → reward drops to 8'h00 immediately, without waiting for a clock edge.
